// File: rtl/clk_div_monitor.sv
// Samples a divided clock in its source domain: rise/fall strobes, period and
// high-time measurement, divide-ratio checking with lock and timeout detection.
module clk_div_monitor #(
  parameter int EXP_DIV     = 3,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_N      = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             div_err,
  output logic             err_sticky,
  output logic             timeout,
  output logic             lock
);

  localparam int              LW      = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] EXP     = CNT_W'(EXP_DIV);
  localparam logic [LW-1:0]    LOCK_V  = LW'(LOCK_N);

  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

  state_t                 r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_lvl_d;
  logic [CNT_W-1:0]       r_per_cnt, r_hi_cnt;
  logic [LW-1:0]          r_match, w_match_nxt;
  logic                   w_lvl, w_rise, w_fall;
  logic                   w_start, w_meas, w_tmo, w_per_match;

  assign w_lvl  = r_sync[SYNC_STAGES-1];
  assign w_rise = w_lvl & ~r_lvl_d;
  assign w_fall = ~w_lvl & r_lvl_d;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_sync  <= '0;
      r_lvl_d <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_lvl_d <= w_lvl;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // A rise always takes priority over saturation; en low overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_meas      = 1'b0;
    w_tmo       = 1'b0;
    if (!en) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: w_state_nxt = ARM;
        ARM: begin
          if (w_rise) begin
            w_state_nxt = MEAS;
            w_start     = 1'b1;
          end
        end
        MEAS: begin
          if (w_rise) begin
            w_meas = 1'b1;
          end else if (r_per_cnt == CNT_MAX) begin
            w_tmo       = 1'b1;
            w_state_nxt = ARM;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
    w_per_match = (r_per_cnt == EXP);
    w_match_nxt = '0;
    if (w_per_match) w_match_nxt = (r_match == LOCK_V) ? r_match : r_match + LW'(1);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      meas_valid <= 1'b0;
      div_err    <= 1'b0;
      timeout    <= 1'b0;
      period     <= '0;
      high_time  <= '0;
      err_sticky <= 1'b0;
      lock       <= 1'b0;
      r_per_cnt  <= '0;
      r_hi_cnt   <= '0;
      r_match    <= '0;
    end else begin
      rise_pulse <= w_rise & (r_state != IDLE);
      fall_pulse <= w_fall & (r_state != IDLE);
      meas_valid <= w_meas;
      div_err    <= w_meas & ~w_per_match;
      timeout    <= w_tmo;
      if (!en || r_state == IDLE) begin
        r_per_cnt  <= '0;
        r_hi_cnt   <= '0;
        r_match    <= '0;
        lock       <= 1'b0;
        err_sticky <= 1'b0;
      end else if (w_start) begin
        // the rising cycle itself is high, so both counts start at 1
        r_per_cnt <= CNT_W'(1);
        r_hi_cnt  <= CNT_W'(1);
      end else if (w_meas) begin
        period    <= r_per_cnt;
        high_time <= r_hi_cnt;
        r_per_cnt <= CNT_W'(1);
        r_hi_cnt  <= CNT_W'(1);
        r_match   <= w_match_nxt;
        lock      <= (w_match_nxt == LOCK_V);
        if (!w_per_match) err_sticky <= 1'b1;
      end else if (w_tmo) begin
        r_per_cnt  <= '0;
        r_hi_cnt   <= '0;
        r_match    <= '0;
        lock       <= 1'b0;
        err_sticky <= 1'b1;
      end else if (r_state == MEAS) begin
        if (r_per_cnt != CNT_MAX)          r_per_cnt <= r_per_cnt + CNT_W'(1);
        if (w_lvl && r_hi_cnt != CNT_MAX) r_hi_cnt  <= r_hi_cnt + CNT_W'(1);
      end
    end
  end

endmodule
